hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and redirect controller for the five-stage RISC-V datapath; it generates the stall, bubble, flush, PC-select and operand-forwarding selects that the datapath consumes. It tracks the destination register and write-back source of every in-flight instruction in a private tag pipeline mirroring ID/EX, EX/MEM and MEM/WB. From each decoding instruction's source registers it decides, one cycle ahead, either to forward or to stall. It sits beside the main decoder at the top level.

## Interface
- No parameters.
- clk  in  1  pipeline clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_rs1, id_rs2  in  5  source registers of instruction in IF/ID
- id_use_rs1, id_use_rs2  in  1  source actually read by that instruction
- id_rd  in  5  destination register
- id_reg_we  in  1  instruction writes the register file
- id_wb_sel  in  2  write-back source: 0 PC-link, 1 memory, 2 ALU
- redirect  in  1  taken branch/jump currently in EX/MEM
- redirect_sel  in  2  1 = ex_pc target, 2 = ex_alu target (jalr)
- if_we  out  1  PC and IF/ID enable
- id_we  out  1  ID/EX enable, constant 1
- bubble_id  out  1  zero control bits entering ID/EX
- flush_ex  out  1  zero control bits entering EX/MEM
- m4_1_cnt  out  2  PC source: 0 PC+4, else redirect_sel
- m8_1_cnt, m8_2_cnt  out  3  EX operand select: 0 normal, 1 ex_pc, 2 ex_alu, 3 mem_pc, 4 mem_alu

## Operation
- Tag stages E, M and W each hold {rd, reg_we, wb_sel, fwd1, fwd2}. A tag with rd = 0 is stored with reg_we = 0.
- A source is hazarded only when it is used, non-zero and equal to a valid tag's rd. The nearest stage wins: E over M over W.
- Producer in E: ALU gives fwd 2, PC-link gives fwd 1, load gives a stall.
- Producer in M: ALU gives fwd 4, PC-link gives fwd 3, load gives a stall.
- Producer in W, any source: stall. Its register-file write races the ID read.
- Stall: if_we = 0 and bubble_id = 1. A null tag (reg_we = 0, fwd 0) enters E.
- No stall: the decoded tag, with its fwd codes, enters E.
- Tags shift E→M→W every cycle. Stages never freeze.
- m8_1_cnt and m8_2_cnt are the E-stage tag's fwd1 and fwd2, registered, so they are valid while the consumer is in EX.
- Redirect sets m4_1_cnt = redirect_sel, if_we = 1, bubble_id = 1 and flush_ex = 1. The E tag moving to M is nulled and kill_q is set.
- When kill_q = 1, the IF/ID contents are junk. Hazard detection is suppressed, bubble_id = 1 and a null tag enters E. kill_q clears the next cycle.
- Redirect beats stall. Redirect during kill_q re-arms kill_q.

## Timing
- Reset clears all tags and kill_q.
- Reset values: if_we = 1, id_we = 1, bubble_id = 0, flush_ex = 0, m4_1_cnt = 0, m8_1_cnt = 0, m8_2_cnt = 0.
- Reset mid-operation discards all tags; no stall persists past the reset cycle.
- if_we, bubble_id, flush_ex and m4_1_cnt are combinational from the ID inputs, the tags and kill_q in the same cycle.
- m8_* come from registers: zero combinational paths from the inputs.
- Load-use costs 3 stall cycles when the consumer immediately follows the load, 2 with one instruction between them, and 1 with two between them.
- Redirect costs 3 squashed slots: ID/EX, IF/ID, and the fetch in flight.

## Configuration
- HAZARD_FWD_EN defined: forwarding as described above.
- HAZARD_FWD_EN undefined: every hazard against E, M or W stalls, and m8_1_cnt and m8_2_cnt are tied to 0.

## Structure
- Package hazard_pkg holds the WB_PC/WB_MEM/WB_ALU constants, the FWD_* select codes, the PC_SEQ/PC_EXPC/PC_EXALU codes and the tag struct.
- Sub-module hazard_tag_stage implements one tag register with synchronous clear and a null-insert input. It is instantiated three times.

## Test plan
- ALU writes x5, next instruction reads rs1 = x5 -> no stall; m8_1_cnt = 2 during the consumer's EX cycle.
- ALU writes x6, one instruction between, consumer reads rs2 = x6 -> m8_2_cnt = 4, m8_1_cnt = 0.
- Load writes x7, next instruction reads x7 -> if_we = 0 and bubble_id = 1 for exactly 3 cycles; the consumer then issues with m8_* = 0.
- jal writes x1, next instruction reads x1 -> m8_1_cnt = 1.
- redirect = 1 with redirect_sel = 2 while a load-use stall is pending -> that cycle: m4_1_cnt = 2, if_we = 1, flush_ex = 1, bubble_id = 1; next cycle: bubble_id = 1 only; then normal flow.
- With HAZARD_FWD_EN undefined, ALU writes x5 and the next instruction reads x5 -> 3 stall cycles with m8_* = 0. Any writer to x0 -> no stall and no forward.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared constants, tag struct and source-hazard check for hazard_ctrl
package hazard_pkg;

    // Write-back source of the producing instruction
    localparam logic [1:0] WB_PC  = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_ALU = 2'd2;

    // EX operand select codes driven on m8_1_cnt / m8_2_cnt
    localparam logic [2:0] FWD_NONE    = 3'd0;
    localparam logic [2:0] FWD_EX_PC   = 3'd1;
    localparam logic [2:0] FWD_EX_ALU  = 3'd2;
    localparam logic [2:0] FWD_MEM_PC  = 3'd3;
    localparam logic [2:0] FWD_MEM_ALU = 3'd4;

    // PC source codes driven on m4_1_cnt
    localparam logic [1:0] PC_SEQ   = 2'd0;
    localparam logic [1:0] PC_EXPC  = 2'd1;
    localparam logic [1:0] PC_EXALU = 2'd2;

    // One in-flight instruction as seen by the hazard logic
    typedef struct packed {
        logic [4:0] rd;
        logic       reg_we;
        logic [1:0] wb_sel;
        logic [2:0] fwd1;
        logic [2:0] fwd2;
    } tag_t;

    // Outcome of checking one decoded source register
    typedef struct packed {
        logic       stall;
        logic [2:0] fwd;
    } src_res_t;

    // Nearest producer wins (E, then M, then W). A W-stage producer always
    // stalls because its register-file write races the ID read. Loads and
    // unknown write-back sources cannot be forwarded and stall too.
    function automatic src_res_t src_check(
        input logic [4:0] rs,
        input logic       used,
        input tag_t       e,
        input tag_t       m,
        input tag_t       w,
        input logic       fwd_en
    );
        src_res_t r;
        r.stall = 1'b0;
        r.fwd   = FWD_NONE;
        if (used && (rs != 5'd0)) begin
            if (e.reg_we && (e.rd == rs)) begin
                if (fwd_en && (e.wb_sel == WB_ALU))
                    r.fwd = FWD_EX_ALU;
                else if (fwd_en && (e.wb_sel == WB_PC))
                    r.fwd = FWD_EX_PC;
                else
                    r.stall = 1'b1;
            end else if (m.reg_we && (m.rd == rs)) begin
                if (fwd_en && (m.wb_sel == WB_ALU))
                    r.fwd = FWD_MEM_ALU;
                else if (fwd_en && (m.wb_sel == WB_PC))
                    r.fwd = FWD_MEM_PC;
                else
                    r.stall = 1'b1;
            end else if (w.reg_we && (w.rd == rs)) begin
                r.stall = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/hazard_tag_stage.sv
// rtl/hazard_tag_stage.sv - one tag register with synchronous clear and null insertion
module hazard_tag_stage
    import hazard_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic ins_null,
    input  tag_t d,
    output tag_t q
);

    tag_t d_norm;

    // Writes to x0 are architecturally void, so they never count as producers
    always_comb begin
        d_norm        = d;
        d_norm.reg_we = d.reg_we && (d.rd != 5'd0);
    end

    // Capture the incoming tag every cycle; reset or null-insert loads an empty tag
    always_ff @(posedge clk) begin
        if (rst || ins_null)
            q <= '0;
        else
            q <= d_norm;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/bubble/flush/PC-select/forward control; HAZARD_FWD_EN enables forwarding
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] id_rd,
    input  logic       id_reg_we,
    input  logic [1:0] id_wb_sel,
    input  logic       redirect,
    input  logic [1:0] redirect_sel,
    output logic       if_we,
    output logic       id_we,
    output logic       bubble_id,
    output logic       flush_ex,
    output logic [1:0] m4_1_cnt,
    output logic [2:0] m8_1_cnt,
    output logic [2:0] m8_2_cnt
);

`ifdef HAZARD_FWD_EN
    localparam logic FWD_EN = 1'b1;
`else
    localparam logic FWD_EN = 1'b0;
`endif

    tag_t     tag_e;
    tag_t     tag_m;
    tag_t     tag_w;
    tag_t     tag_id;
    logic     kill_q;
    src_res_t res1;
    src_res_t res2;
    logic     stall_raw;

    // Classify both decoded sources against the in-flight producers
    always_comb begin
        res1      = src_check(id_rs1, id_use_rs1, tag_e, tag_m, tag_w, FWD_EN);
        res2      = src_check(id_rs2, id_use_rs2, tag_e, tag_m, tag_w, FWD_EN);
        stall_raw = res1.stall | res2.stall;
    end

    // Pipeline control: reset, then redirect, then post-redirect kill, then stall
    always_comb begin
        if_we     = 1'b1;
        bubble_id = 1'b0;
        flush_ex  = 1'b0;
        m4_1_cnt  = PC_SEQ;
        if (rst) begin
            if_we     = 1'b1;
        end else if (redirect) begin
            m4_1_cnt  = redirect_sel;
            bubble_id = 1'b1;
            flush_ex  = 1'b1;
        end else if (kill_q) begin
            bubble_id = 1'b1;
        end else if (stall_raw) begin
            if_we     = 1'b0;
            bubble_id = 1'b1;
        end
    end

    assign id_we = 1'b1;

    // Tag describing the instruction now in ID, with the forward codes it will use in EX
    always_comb begin
        tag_id        = '0;
        tag_id.rd     = id_rd;
        tag_id.reg_we = id_reg_we;
        tag_id.wb_sel = id_wb_sel;
        tag_id.fwd1   = res1.fwd;
        tag_id.fwd2   = res2.fwd;
    end

    hazard_tag_stage u_stage_e (
        .clk      (clk),
        .rst      (rst),
        .ins_null (bubble_id),
        .d        (tag_id),
        .q        (tag_e)
    );

    hazard_tag_stage u_stage_m (
        .clk      (clk),
        .rst      (rst),
        .ins_null (redirect),
        .d        (tag_e),
        .q        (tag_m)
    );

    hazard_tag_stage u_stage_w (
        .clk      (clk),
        .rst      (rst),
        .ins_null (1'b0),
        .d        (tag_m),
        .q        (tag_w)
    );

    // IF/ID holds a wrong-path instruction for exactly one cycle after each redirect
    always_ff @(posedge clk) begin
        if (rst)
            kill_q <= 1'b0;
        else
            kill_q <= redirect;
    end

`ifdef HAZARD_FWD_EN
    assign m8_1_cnt = tag_e.fwd1;
    assign m8_2_cnt = tag_e.fwd2;

    logic unused_tag_bits;
    assign unused_tag_bits = ^{tag_w.fwd1, tag_w.fwd2, tag_w.wb_sel};
`else
    assign m8_1_cnt = FWD_NONE;
    assign m8_2_cnt = FWD_NONE;

    logic unused_tag_bits;
    assign unused_tag_bits = ^{tag_e.fwd1, tag_e.fwd2, tag_w.fwd1, tag_w.fwd2, tag_w.wb_sel};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl with directed vectors
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs1 = '0;
    logic [4:0] id_rs2 = '0;
    logic       id_use_rs1 = 1'b0;
    logic       id_use_rs2 = 1'b0;
    logic [4:0] id_rd = '0;
    logic       id_reg_we = 1'b0;
    logic [1:0] id_wb_sel = '0;
    logic       redirect = 1'b0;
    logic [1:0] redirect_sel = '0;
    logic       if_we;
    logic       id_we;
    logic       bubble_id;
    logic       flush_ex;
    logic [1:0] m4_1_cnt;
    logic [2:0] m8_1_cnt;
    logic [2:0] m8_2_cnt;

    typedef struct {
        logic [11:0] v;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    logic [11:0] R;
    logic [11:0] S;

    hazard_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rd        (id_rd),
        .id_reg_we    (id_reg_we),
        .id_wb_sel    (id_wb_sel),
        .redirect     (redirect),
        .redirect_sel (redirect_sel),
        .if_we        (if_we),
        .id_we        (id_we),
        .bubble_id    (bubble_id),
        .flush_ex     (flush_ex),
        .m4_1_cnt     (m4_1_cnt),
        .m8_1_cnt     (m8_1_cnt),
        .m8_2_cnt     (m8_2_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] ev(input logic ifw, input logic bub, input logic fl,
                                       input logic [1:0] m4, input logic [2:0] a, input logic [2:0] b);
        return {ifw, 1'b1, bub, fl, m4, a, b};
    endfunction

    // Drive one ID-stage cycle and queue the outputs expected during it
    task automatic drv(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic [4:0] rd, input logic we, input logic [1:0] wb,
                       input logic rdr, input logic [1:0] rsel, input logic [11:0] e, input string name);
        exp_t x;
        id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = rd; id_reg_we = we; id_wb_sel = wb;
        redirect = rdr; redirect_sel = rsel;
        x.v = e; x.name = name;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input logic [11:0] e, input string name);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, e, name);
    endtask

    // Monitor: compare every queued expectation against the outputs mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            logic [11:0] act;
            x = exp_q.pop_front();
            act = {if_we, id_we, bubble_id, flush_ex, m4_1_cnt, m8_1_cnt, m8_2_cnt};
            checks = checks + 1;
            if (act !== x.v) begin
                failures = failures + 1;
                $display("FAIL %s: got if_we/id_we/bub/flush/m4/m8_1/m8_2 = %b/%b/%b/%b/%0d/%0d/%0d expected %b/%b/%b/%b/%0d/%0d/%0d",
                         x.name, act[11], act[10], act[9], act[8], act[7:6], act[5:3], act[2:0],
                         x.v[11], x.v[10], x.v[9], x.v[8], x.v[7:6], x.v[5:3], x.v[2:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        R = ev(1, 0, 0, 0, 0, 0);
        S = ev(0, 1, 0, 0, 0, 0);

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        drv(5, 5, 1, 1, 5, 1, 1, 1, 2, R, "reset_outputs");
        rst = 1'b0;
        nop(R, "post_reset_idle");

        // load-use, consumer immediately after: 3 stall cycles
        drv(0, 0, 0, 0, 7, 1, 1, 0, 0, R, "ld7_issue");
        drv(7, 0, 1, 0, 11, 1, 2, 0, 0, S, "ld_use_stall1");
        drv(7, 0, 1, 0, 11, 1, 2, 0, 0, S, "ld_use_stall2");
        drv(7, 0, 1, 0, 11, 1, 2, 0, 0, S, "ld_use_stall3");
        drv(7, 0, 1, 0, 11, 1, 2, 0, 0, R, "ld_use_issue");
        nop(R, "ld_use_ex_m8_zero");
        nop(R, "drain_a1"); nop(R, "drain_a2");

        // load with two instructions between: 1 stall cycle on rs2
        drv(0, 0, 0, 0, 8, 1, 1, 0, 0, R, "ld8_issue");
        nop(R, "ld8_gap1");
        nop(R, "ld8_gap2");
        drv(0, 8, 0, 1, 0, 0, 0, 0, 0, S, "ld_gap2_stall");
        drv(0, 8, 0, 1, 0, 0, 0, 0, 0, R, "ld_gap2_issue");
        nop(R, "drain_b1"); nop(R, "drain_b2"); nop(R, "drain_b3");

        // x0 writer and unused sources never hazard
        drv(0, 0, 0, 0, 0, 1, 2, 0, 0, R, "x0_writer");
        drv(0, 0, 1, 1, 15, 1, 2, 0, 0, R, "x0_reader");
        drv(0, 0, 0, 0, 9, 1, 2, 0, 0, R, "alu9_issue");
        drv(9, 9, 0, 0, 16, 1, 2, 0, 0, R, "unused_src_no_stall");
        nop(R, "unused_src_m8_zero");
        nop(R, "drain_c1"); nop(R, "drain_c2");

        // redirect beats a pending load-use stall and squashes the load
        drv(0, 0, 0, 0, 10, 1, 1, 0, 0, R, "ld10_issue");
        drv(10, 0, 1, 0, 12, 1, 2, 1, 2, ev(1, 1, 1, 2, 0, 0), "redir_over_stall");
        drv(10, 0, 1, 0, 12, 1, 2, 0, 0, ev(1, 1, 0, 0, 0, 0), "redir_kill");
        drv(10, 0, 1, 0, 12, 1, 2, 0, 0, R, "redir_load_nulled");
        nop(R, "redir_normal");

        // redirect during kill re-arms the kill
        drv(0, 0, 0, 0, 0, 0, 0, 1, 1, ev(1, 1, 1, 1, 0, 0), "redir_first");
        drv(0, 0, 0, 0, 0, 0, 0, 1, 1, ev(1, 1, 1, 1, 0, 0), "redir_rearm");
        nop(ev(1, 1, 0, 0, 0, 0), "rearm_kill");
        nop(R, "rearm_normal");

        // reset mid-operation discards tags and kill
        drv(0, 0, 0, 0, 13, 1, 1, 0, 0, R, "ld13_issue");
        rst = 1'b1;
        drv(13, 0, 1, 0, 0, 0, 0, 0, 0, R, "rst_mid_outputs");
        rst = 1'b0;
        drv(13, 0, 1, 0, 0, 0, 0, 0, 0, R, "rst_tags_cleared");
        nop(R, "drain_d1");
        drv(0, 0, 0, 0, 0, 0, 0, 1, 1, ev(1, 1, 1, 1, 0, 0), "redir_before_rst");
        rst = 1'b1;
        nop(R, "rst_during_kill");
        rst = 1'b0;
        nop(R, "rst_clears_kill");
        nop(R, "drain_d2"); nop(R, "drain_d3");

`ifdef HAZARD_FWD_EN
        // forwarding from E (ALU), M (ALU) and E (PC-link)
        drv(0, 0, 0, 0, 5, 1, 2, 0, 0, R, "fwd_alu5_issue");
        drv(5, 0, 1, 0, 14, 1, 2, 0, 0, R, "fwd_ex_no_stall");
        nop(ev(1, 0, 0, 0, 2, 0), "fwd_ex_alu_m8");
        nop(R, "drain_f1"); nop(R, "drain_f2"); nop(R, "drain_f3");
        drv(0, 0, 0, 0, 6, 1, 2, 0, 0, R, "fwd_alu6_issue");
        nop(R, "fwd_gap");
        drv(0, 6, 0, 1, 17, 1, 2, 0, 0, R, "fwd_mem_no_stall");
        nop(ev(1, 0, 0, 0, 0, 4), "fwd_mem_alu_m8");
        nop(R, "drain_f4"); nop(R, "drain_f5"); nop(R, "drain_f6");
        drv(0, 0, 0, 0, 1, 1, 0, 0, 0, R, "fwd_jal_issue");
        drv(1, 0, 1, 0, 18, 1, 2, 0, 0, R, "fwd_jal_no_stall");
        nop(ev(1, 0, 0, 0, 1, 0), "fwd_ex_pc_m8");
`else
        // without forwarding every hazard stalls until the producer leaves W
        drv(0, 0, 0, 0, 5, 1, 2, 0, 0, R, "nf_alu5_issue");
        drv(5, 0, 1, 0, 14, 1, 2, 0, 0, S, "nf_alu_stall1");
        drv(5, 0, 1, 0, 14, 1, 2, 0, 0, S, "nf_alu_stall2");
        drv(5, 0, 1, 0, 14, 1, 2, 0, 0, S, "nf_alu_stall3");
        drv(5, 0, 1, 0, 14, 1, 2, 0, 0, R, "nf_alu_issue");
        nop(R, "nf_alu_m8_zero");
        nop(R, "drain_n1"); nop(R, "drain_n2");
        drv(0, 0, 0, 0, 6, 1, 2, 0, 0, R, "nf_alu6_issue");
        nop(R, "nf_gap");
        drv(0, 6, 0, 1, 17, 1, 2, 0, 0, S, "nf_gap_stall1");
        drv(0, 6, 0, 1, 17, 1, 2, 0, 0, S, "nf_gap_stall2");
        drv(0, 6, 0, 1, 17, 1, 2, 0, 0, R, "nf_gap_issue");
        nop(R, "drain_n3"); nop(R, "drain_n4"); nop(R, "drain_n5");
        drv(0, 0, 0, 0, 1, 1, 0, 0, 0, R, "nf_jal_issue");
        drv(1, 0, 1, 0, 18, 1, 2, 0, 0, S, "nf_jal_stall1");
        drv(1, 0, 1, 0, 18, 1, 2, 0, 0, S, "nf_jal_stall2");
        drv(1, 0, 1, 0, 18, 1, 2, 0, 0, S, "nf_jal_stall3");
        drv(1, 0, 1, 0, 18, 1, 2, 0, 0, R, "nf_jal_issue_consumer");
`endif
        nop(R, "final_idle");

        repeat (4) begin
            if (exp_q.size() != 0) @(negedge clk);
        end
        #1;
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
